hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the five-stage RISC-V core (F/D/E/M/W). Generates stall, flush and forwarding controls for the pipeline registers and E-stage operand muxes. Resolves load-use and branch/jump hazards and freezes the pipeline while data memory is not ready. Also sequences a post-reset pipeline flush, detects memory-wait timeouts and counts stall cycles.

## Interface
- `BOOT_CYCLES`, default 2: cycles of forced D/E flush after reset release (≥1).
- `MAX_WAIT`, default 255: memory-wait cycles allowed before timeout (≥1).
- `CNT_W`, default 32: stall-counter width.
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `Rs1D`, `Rs2D` in 5 each: source registers in D.
- `Rs1E`, `Rs2E`, `RdE` in 5 each: source and destination registers in E.
- `RdM`, `RdW` in 5 each: destination registers in M and W.
- `RegWriteM`, `RegWriteW` in 1 each: register-file write enables in M and W.
- `ResultSrcE0` in 1: instruction in E is a load.
- `PCSrcE` in 1: taken branch/jump resolved in E.
- `MemReqM` in 1: M-stage instruction accesses data memory.
- `MemReadyM` in 1: data memory completes the access this cycle.
- `StallF`, `StallD`, `StallE`, `StallM` out 1 each: hold the corresponding pipeline register.
- `FlushD`, `FlushE`, `FlushW` out 1 each: clear the corresponding pipeline register to a bubble.
- `ForwardAE`, `ForwardBE` out 2 each: E operand select. 00 = register file, 01 = W result, 10 = M ALU result.
- `MemTimeout` out 1: sticky error flag.
- `StallCount` out `CNT_W`: total cycles with `StallF`=1.

## Operation
- States: BOOT, RUN, MEMWAIT.
- Reset: state BOOT, boot counter 0, wait counter 0, `MemTimeout`=0, `StallCount`=0.
- BOOT:
  - Outputs: `StallF`=1, `FlushD`=`FlushE`=1, all other stall/flush outputs 0.
  - Go to RUN after `BOOT_CYCLES` cycles with reset low.
  - Memory inputs are ignored.
- RUN:
  - lwStall = `ResultSrcE0` & `RdE`≠0 & (`Rs1D`==`RdE` | `Rs2D`==`RdE`).
  - `StallF`=`StallD`=lwStall.
  - `FlushD`=`PCSrcE`; `FlushE`=lwStall | `PCSrcE`.
  - `StallE`=`StallM`=`FlushW`=0.
  - If `MemReqM` & !`MemReadyM`: memStall applies this cycle and the next state is MEMWAIT.
- memStall (RUN entry cycle and every MEMWAIT cycle where `MemReadyM`=0):
  - `StallF`/`StallD`/`StallE`/`StallM`=1, `FlushW`=1, `FlushD`=`FlushE`=0.
  - Overrides lwStall and `PCSrcE`: E is frozen, so its redirect is taken after the stall.
- MEMWAIT:
  - The wait counter increments each cycle.
  - `MemReadyM`=1 in a cycle: no memStall that cycle, RUN equations apply, wait counter clears, next state RUN.
  - Wait counter reaching `MAX_WAIT`: set `MemTimeout` (held until reset). The FSM stays in MEMWAIT; there is no recovery without ready.
- Forwarding:
  - `ForwardAE`=10 if `RegWriteM` & `RdM`==`Rs1E` & `Rs1E`≠0.
  - Else 01 if `RegWriteW` & `RdW`==`Rs1E` & `Rs1E`≠0.
  - Else 00. `ForwardBE` is the same using `Rs2E`.
  - M has priority over W. Computed in every state.
- `StallCount`: +1 on each cycle with `StallF`=1, including BOOT. Saturates at all-ones.

## Timing
- Stall, flush and forward outputs are combinational from the current inputs and registered state (zero latency).
- State, counters and `MemTimeout` update on the rising edge.
- Reset values: `StallF`=1, `FlushD`=`FlushE`=1; `StallD`/`StallE`/`StallM`/`FlushW`=0; `ForwardAE`/`ForwardBE` follow their inputs; `MemTimeout`=0; `StallCount`=0.
- Reset asserted mid-MEMWAIT or mid-BOOT: next cycle is BOOT with both counters cleared.
- Simultaneous lwStall and `PCSrcE` in RUN: `StallF`=`StallD`=1, `FlushD`=`FlushE`=1.
- `MemReqM` & `MemReadyM` in the same cycle: no stall.
- x0 as destination never forwards and never causes a load-use stall.

## Structure
- Shared package `pipe_pkg`:
  - state enum (BOOT, RUN, MEMWAIT).
  - forward select constants FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10.
- One natural sub-module, `forward_unit`: combinational, two instances (operand A, operand B).
- FSM, counters and stall/flush logic live in `hazard_ctrl`.

## Test plan
- Reset, then release with `BOOT_CYCLES`=2 → 2 cycles of `StallF`=`FlushD`=`FlushE`=1, then RUN with all outputs 0; `StallCount`=2.
- Load in E with `RdE`=5 and `Rs2D`=5 → `StallF`=`StallD`=`FlushE`=1 for one cycle. Repeat with `RdE`=0 → no stall.
- `RegWriteM`=`RegWriteW`=1, `RdM`=`RdW`=`Rs1E`=7 → `ForwardAE`=10. With `RegWriteM`=0 → 01.
- `MemReqM`=1, `MemReadyM` low for 3 cycles with `PCSrcE`=1 throughout → `StallF`/`StallD`/`StallE`/`StallM`/`FlushW`=1 and `FlushD`=`FlushE`=0 for 3 cycles. On the ready cycle, `FlushD`=`FlushE`=1 and state returns to RUN.
- `MAX_WAIT`=4, `MemReadyM` held low → `MemTimeout` rises after 4 MEMWAIT cycles and stays high. Reset clears it.
- Reset asserted during MEMWAIT → BOOT next cycle, wait counter 0, memStall outputs drop.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared FSM state and forwarding-select encodings for the pipeline hazard logic.
package pipe_pkg;
    typedef enum logic [1:0] {BOOT, RUN, MEMWAIT} state_t;
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;
endpackage

// File: rtl/forward_unit.sv
// forward_unit: E-stage operand bypass select, M result preferred over W, x0 never forwarded.
module forward_unit
    import pipe_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] rd_m,
    input  logic [4:0] rd_w,
    input  logic       reg_write_m,
    input  logic       reg_write_w,
    output logic [1:0] fwd
);
    always_comb
        fwd = (reg_write_m && rd_m == rs && rs != 5'd0) ? FWD_M :
              (reg_write_w && rd_w == rs && rs != 5'd0) ? FWD_W : FWD_RF;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forward control for the five-stage pipeline, with boot flush,
// memory-wait freeze and timeout, and a saturating stall-cycle counter.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int BOOT_CYCLES = 2,
    parameter int MAX_WAIT    = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             ResultSrcE0,
    input  logic             PCSrcE,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             MemTimeout,
    output logic [CNT_W-1:0] StallCount
);
    localparam int BW = $clog2(BOOT_CYCLES + 1);
    localparam int WW = $clog2(MAX_WAIT + 1);

    state_t        state;
    logic [BW-1:0] boot_cnt;
    logic [WW-1:0] wait_cnt;
    logic          boot, lw_stall, mem_stall;

    forward_unit fwd_a (.rs(Rs1E), .rd_m(RdM), .rd_w(RdW), .reg_write_m(RegWriteM),
                        .reg_write_w(RegWriteW), .fwd(ForwardAE));
    forward_unit fwd_b (.rs(Rs2E), .rd_m(RdM), .rd_w(RdW), .reg_write_m(RegWriteM),
                        .reg_write_w(RegWriteW), .fwd(ForwardBE));

    // A memory freeze holds E, so any redirect resolved there is deferred until after it.
    always_comb begin
        boot      = state == BOOT;
        lw_stall  = ResultSrcE0 && RdE != 5'd0 && (Rs1D == RdE || Rs2D == RdE);
        mem_stall = !MemReadyM && ((state == RUN && MemReqM) || state == MEMWAIT);
        StallF    = boot || mem_stall || lw_stall;
        StallD    = !boot && (mem_stall || lw_stall);
        StallE    = mem_stall;
        StallM    = mem_stall;
        FlushW    = mem_stall;
        FlushD    = boot || (!mem_stall && PCSrcE);
        FlushE    = boot || (!mem_stall && (lw_stall || PCSrcE));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= BOOT;
            boot_cnt   <= '0;
            wait_cnt   <= '0;
            MemTimeout <= 1'b0;
            StallCount <= '0;
        end else begin
            if (StallF && StallCount != '1) StallCount <= StallCount + 1'b1;
            case (state)
                BOOT: begin
                    boot_cnt <= (boot_cnt == BW'(BOOT_CYCLES - 1)) ? '0 : boot_cnt + 1'b1;
                    if (boot_cnt == BW'(BOOT_CYCLES - 1)) state <= RUN;
                end
                RUN: if (MemReqM && !MemReadyM) state <= MEMWAIT;
                MEMWAIT: begin
                    if (MemReadyM) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else begin
                        if (wait_cnt != WW'(MAX_WAIT)) wait_cnt <= wait_cnt + 1'b1;
                        if (wait_cnt == WW'(MAX_WAIT - 1)) MemTimeout <= 1'b1;
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vectors with hand-computed expectations, checked through a scoreboard queue.
module tb_hazard_ctrl;
    logic       clk = 0, reset = 1;
    logic [4:0] Rs1D = 0, Rs2D = 0, Rs1E = 0, Rs2E = 0, RdE = 0, RdM = 0, RdW = 0;
    logic       RegWriteM = 0, RegWriteW = 0, ResultSrcE0 = 0, PCSrcE = 0, MemReqM = 0, MemReadyM = 0;
    logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemTimeout;
    logic [1:0] ForwardAE, ForwardBE;
    logic [7:0] StallCount;

    typedef struct {
        string      name;
        logic [6:0] ctl;
        logic [1:0] fa, fb;
        logic       to;
        logic [7:0] cnt;
    } exp_t;
    exp_t q[$];
    int total = 0, bad = 0;

    // ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
    localparam logic [6:0] C_BOOT = 7'b1000110, C_NONE = 7'b0000000, C_LW = 7'b1100010;
    localparam logic [6:0] C_MEM = 7'b1111001, C_BR = 7'b0000110, C_LWBR = 7'b1100110;

    hazard_ctrl #(.BOOT_CYCLES(2), .MAX_WAIT(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM), .FlushD(FlushD),
        .FlushE(FlushE), .FlushW(FlushW), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .MemTimeout(MemTimeout), .StallCount(StallCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [6:0] ctl, input logic [1:0] fa, input logic [1:0] fb,
                       input logic to, input logic [7:0] cnt);
        q.push_back('{name, ctl, fa, fb, to, cnt});
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
        {RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MemReqM, MemReadyM} = '0;
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            logic [6:0] act;
            e = q.pop_front();
            act = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};
            total++;
            if ({act, ForwardAE, ForwardBE, MemTimeout, StallCount} !== {e.ctl, e.fa, e.fb, e.to, e.cnt}) begin
                bad++;
                $display("FAIL %s: got ctl=%b fa=%b fb=%b to=%b cnt=%0d, want ctl=%b fa=%b fb=%b to=%b cnt=%0d",
                         e.name, act, ForwardAE, ForwardBE, MemTimeout, StallCount,
                         e.ctl, e.fa, e.fb, e.to, e.cnt);
            end
        end
    end

    initial begin
        idle();
        chk("reset", C_BOOT, 2'b00, 2'b00, 0, 0);
        reset = 0;
        chk("boot0", C_BOOT, 2'b00, 2'b00, 0, 0);
        chk("boot1", C_BOOT, 2'b00, 2'b00, 0, 1);
        chk("run_idle", C_NONE, 2'b00, 2'b00, 0, 2);
        ResultSrcE0 = 1; RdE = 5; Rs2D = 5;
        chk("load_use", C_LW, 2'b00, 2'b00, 0, 2);
        clr();
        chk("after_load_use", C_NONE, 2'b00, 2'b00, 0, 3);
        ResultSrcE0 = 1; RdE = 0; Rs1D = 0; Rs2D = 0;
        chk("load_x0", C_NONE, 2'b00, 2'b00, 0, 3);
        clr();
        RegWriteM = 1; RegWriteW = 1; RdM = 7; RdW = 7; Rs1E = 7;
        chk("fwd_m_prio", C_NONE, 2'b10, 2'b00, 0, 3);
        RegWriteM = 0;
        chk("fwd_w", C_NONE, 2'b01, 2'b00, 0, 3);
        RegWriteM = 1; RdM = 3; Rs2E = 3;
        chk("fwd_b_m", C_NONE, 2'b01, 2'b10, 0, 3);
        Rs1E = 0; RdW = 0; RdM = 0; Rs2E = 0;
        chk("fwd_x0", C_NONE, 2'b00, 2'b00, 0, 3);
        clr();
        ResultSrcE0 = 1; RdE = 9; Rs1D = 9; PCSrcE = 1;
        chk("lw_and_branch", C_LWBR, 2'b00, 2'b00, 0, 3);
        clr();
        MemReqM = 1; PCSrcE = 1;
        chk("mem_enter", C_MEM, 2'b00, 2'b00, 0, 4);
        chk("mem_wait1", C_MEM, 2'b00, 2'b00, 0, 5);
        chk("mem_wait2", C_MEM, 2'b00, 2'b00, 0, 6);
        MemReadyM = 1;
        chk("mem_ready_br", C_BR, 2'b00, 2'b00, 0, 7);
        clr();
        chk("mem_back_run", C_NONE, 2'b00, 2'b00, 0, 7);
        MemReqM = 1; MemReadyM = 1;
        chk("req_ready_same", C_NONE, 2'b00, 2'b00, 0, 7);
        MemReadyM = 0;
        chk("to_enter", C_MEM, 2'b00, 2'b00, 0, 7);
        chk("to_w1", C_MEM, 2'b00, 2'b00, 0, 8);
        chk("to_w2", C_MEM, 2'b00, 2'b00, 0, 9);
        chk("to_w3", C_MEM, 2'b00, 2'b00, 0, 10);
        chk("to_w4", C_MEM, 2'b00, 2'b00, 0, 11);
        chk("to_set", C_MEM, 2'b00, 2'b00, 1, 12);
        chk("to_hold", C_MEM, 2'b00, 2'b00, 1, 13);
        MemReadyM = 1;
        chk("to_ready", C_NONE, 2'b00, 2'b00, 1, 14);
        clr();
        chk("to_sticky", C_NONE, 2'b00, 2'b00, 1, 14);
        MemReqM = 1;
        chk("rst_enter", C_MEM, 2'b00, 2'b00, 1, 14);
        chk("rst_wait", C_MEM, 2'b00, 2'b00, 1, 15);
        reset = 1;
        idle();
        reset = 0;
        chk("rst_boot0", C_BOOT, 2'b00, 2'b00, 0, 0);
        clr();
        chk("rst_boot1", C_BOOT, 2'b00, 2'b00, 0, 1);
        MemReqM = 1;
        chk("rst_run_enter", C_MEM, 2'b00, 2'b00, 0, 2);
        chk("rst_w1", C_MEM, 2'b00, 2'b00, 0, 3);
        chk("rst_w2", C_MEM, 2'b00, 2'b00, 0, 4);
        chk("rst_w3", C_MEM, 2'b00, 2'b00, 0, 5);
        chk("rst_w4", C_MEM, 2'b00, 2'b00, 0, 6);
        chk("rst_to_set", C_MEM, 2'b00, 2'b00, 1, 7);
        for (int i = 0; i < 4 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
